// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-requester round-robin sequencer for a single-port memory.
// Each access is IDLE -> ISSUE (-> RDATA for reads); all outputs are registered.
module mem_rr_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            gnt,
   output logic [1:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
   state_t              r_state, w_next;
   logic                r_sel, r_prio;
   logic                w_start, w_sel;
   logic [1:0]          w_gnt, w_rvalid;
   logic                w_mem_en, w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata, w_rdata;

   // prio only breaks ties; a lone requester always wins
   assign w_start = (r_state == IDLE) && (req != 2'b00);
   assign w_sel   = (req == 2'b11) ? r_prio : req[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_sel     <= 1'b0;
         r_prio    <= 1'b0;
         gnt       <= '0;
         rvalid    <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         r_state   <= w_next;
         r_sel     <= w_start ? w_sel : r_sel;
         r_prio    <= w_start ? !w_sel : r_prio;
         gnt       <= w_gnt;
         rvalid    <= w_rvalid;
         rdata     <= w_rdata;
         busy      <= (w_next != IDLE);
         mem_en    <= w_mem_en;
         mem_we    <= w_mem_we;
         mem_addr  <= w_mem_addr;
         mem_wdata <= w_mem_wdata;
      end
   end

   // mem_we still holds the issued access type while in ISSUE
   always_comb begin
      w_next = (r_state == IDLE)  ? (w_start ? ISSUE : IDLE) :
               (r_state == ISSUE) ? (mem_we ? IDLE : RDATA) : IDLE;
   end

   always_comb begin
      w_gnt       = w_start ? {w_sel, !w_sel} : 2'b00;
      w_mem_en    = w_start;
      w_mem_we    = w_start && (w_sel ? we[1] : we[0]);
      w_mem_addr  = !w_start ? mem_addr :
                    w_sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
      w_mem_wdata = !w_start ? mem_wdata :
                    w_sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      w_rvalid    = (r_state == RDATA) ? {r_sel, !r_sel} : 2'b00;
      w_rdata     = (r_state == RDATA) ? mem_rdata : rdata;
   end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the team's 1024 x 8 single-port memory.
- The memory is preloaded from mem.dat.
- The block serialises requester read and write transactions onto the one memory port.
- It returns read data to the requester that issued the read.
- It sits between the client blocks and the memory instance; it owns mem_en and mem_we exclusively.

Parameters:
ADDR_W, 10, address width; memory depth is 2**ADDR_W = 1024.
DATA_W, 8, data width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  2  per-requester request; bit i belongs to requester i.
we  input  2  per-requester write enable; 1 = write, 0 = read.
addr  input  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
wdata  input  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
gnt  output  2  one-cycle accept pulse, one-hot.
rvalid  output  2  one-cycle read-data-valid pulse, one-hot.
rdata  output  DATA_W  read data; valid only while rvalid is nonzero.
busy  output  1  high while the state is not IDLE.
mem_en  output  1  memory port enable.
mem_we  output  1  memory write enable.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_rdata  input  DATA_W  memory read data; valid the cycle after an edge that sampled mem_en=1 with mem_we=0.

Behaviour:
- Single clock; reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, prio=0.
- FSM states: IDLE, ISSUE, RDATA.
- IDLE, no req bit set: hold the state; mem_en=0.
- IDLE, any req bit set, at edge k:
  - Select requester sel. If only one bit is set, sel is that requester. If both are set, sel=prio.
  - Load mem_en=1, mem_we=we[sel], mem_addr and mem_wdata from sel's fields. Set gnt[sel]=1.
  - Latch sel. Set prio=~sel. Go to ISSUE.
- ISSUE, edge k+1: memory performs the access. Clear gnt, mem_en and mem_we. If the access was a write go to IDLE; if a read go to RDATA.
- RDATA, edge k+2: rdata=mem_rdata; rvalid[sel]=1; go to IDLE.
- rvalid clears at edge k+3.
- A new request can be sampled in IDLE at edge k+2 after a write, or edge k+3 after a read.
- Per-access cost: write = 2 cycles; read = 3 cycles; latency from gnt to rvalid = 2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt[i] is seen.
  - Deassert req, or present the next transaction, in the cycle after gnt.
  - Requests are sampled only in IDLE. A req raised and dropped while the block is busy is lost; this is legal and no access occurs.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1... A lone requester is served back to back regardless of prio.
- No address checking is needed: ADDR_W covers the full depth, so no wrap-around can occur.
- Reset mid-operation: an in-flight access is abandoned, mem_en drops immediately, and no rvalid is produced. The memory contents at that address are undefined only if rst_n fell during the ISSUE cycle of a write.
- gnt, rvalid and mem_en are never simultaneously high for different requesters. gnt and rvalid are each one-hot or zero.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with req=00. Check all outputs stay 0 and busy=0 for 10 cycles.
- Single read: mem.dat has 0xA5 at 0x005. Requester 0 reads 0x005. Check gnt=01 one cycle after sampling; mem_en high for exactly 1 cycle; rvalid=01 with rdata=0xA5 two cycles after gnt.
- Write then read: requester 1 writes 0x3C to 0x3FF, then reads 0x3FF. Check gnt=10 for each; rvalid=10 with rdata=0x3C; mem_addr=0x3FF in both accesses.
- Contention: both requesters hold req with reads of 0x000 and 0x001 for 4 transactions. Check the gnt sequence is 01,10,01,10 (prio starts at 0) and each rvalid is routed to the correct requester.
- Lone requester: requester 1 issues 3 back-to-back writes while req[0]=0. Check gnt=10 each time with a 2-cycle spacing.
- Reset mid-read: assert rst_n=0 in the RDATA cycle. Check rvalid never pulses, all outputs return to 0 asynchronously, and the next read after reset works normally.
